// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl
//   Machine-level interrupt source: a memory-mapped 64-bit mtime/mtimecmp
//   timer with prescaler, plus one synchronised external interrupt line.
//   It raises a trap request toward the CSR/trap unit, holds it until the
//   core acknowledges it, and then waits for MRET before raising another.
//
//   Trap handshake (initiator side):
//     irq_req is registered. Once high it holds, with irq_cause stable,
//     until an irq_ack pulse is seen (the request is then consumed) or
//     software withdraws it by clearing irq_en. irq_ack while irq_req is
//     low and is_mret outside SERVICE are ignored. A new request can only
//     be raised after is_mret returns the controller to IDLE.
//
//   Register map (byte addresses, word aligned):
//     0x00 mtime[31:0]      0x04 mtime[63:32]
//     0x08 mtimecmp[31:0]   0x0C mtimecmp[63:32]
//     0x10 CTRL: [0] timer_en, [1] irq_en, [15:8] prescale,
//                [17:16] controller state (read-only)
//   Unmapped reads return 0; unmapped writes are ignored.

module timer_irq_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int PRESC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    input  logic              bus_we,
    input  logic              bus_re,
    output logic [31:0]       bus_rdata,
    input  logic              ext_irq,
    input  logic              irq_ack,
    input  logic              is_mret,
    output logic              irq_req,
    output logic [31:0]       irq_cause,
    output logic              mtip
);

    // Register addresses
    localparam logic [ADDR_W-1:0] A_MTIME_LO    = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_MTIME_HI    = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_MTIMECMP_LO = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_MTIMECMP_HI = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] A_CTRL        = ADDR_W'(32'h10);

    // mcause values: interrupt bit set, code 11 (external) or 7 (timer)
    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Architectural registers
    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    logic               timer_en;
    logic               irq_en;
    logic [PRESC_W-1:0] prescale;
    logic [PRESC_W-1:0] presc_cnt;

    // External interrupt synchroniser
    logic               ext_meta;
    logic               ext_s;

    // Controller state
    state_t             state;

    // Write strobes per register
    logic               wr_mtime_lo;
    logic               wr_mtime_hi;
    logic               wr_mtimecmp_lo;
    logic               wr_mtimecmp_hi;
    logic               wr_ctrl;

    // Derived control
    logic               tick;
    logic               irq_en_nxt;
    logic               src_active;

    // Decode single-cycle write strobes from the bus
    always_comb begin
        wr_mtime_lo    = bus_we && (bus_addr == A_MTIME_LO);
        wr_mtime_hi    = bus_we && (bus_addr == A_MTIME_HI);
        wr_mtimecmp_lo = bus_we && (bus_addr == A_MTIMECMP_LO);
        wr_mtimecmp_hi = bus_we && (bus_addr == A_MTIMECMP_HI);
        wr_ctrl        = bus_we && (bus_addr == A_CTRL);
    end

    // A tick fires when the running prescaler reaches the programmed divisor.
    // irq_en_nxt is the value irq_en takes after this cycle, so a CTRL write
    // that clears irq_en withdraws a pending request on the same edge.
    always_comb begin
        tick       = timer_en && (presc_cnt == prescale);
        irq_en_nxt = wr_ctrl ? bus_wdata[1] : irq_en;
        src_active = ext_s || mtip;
    end

    // Timer pending level, unsigned 64-bit compare straight off the registers
    always_comb begin
        mtip = (mtime >= mtimecmp);
    end

    // Two-flop synchroniser for the asynchronous external interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_meta <= 1'b0;
            ext_s    <= 1'b0;
        end else begin
            ext_meta <= ext_irq;
            ext_s    <= ext_meta;
        end
    end

    // CTRL register fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_en <= 1'b0;
            irq_en   <= 1'b0;
            prescale <= '0;
        end else if (wr_ctrl) begin
            timer_en <= bus_wdata[0];
            irq_en   <= bus_wdata[1];
            prescale <= bus_wdata[8 +: PRESC_W];
        end
    end

    // Prescaler: runs only while enabled, restarts on any CTRL write or tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (wr_ctrl || !timer_en || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // mtime: a bus write to either half wins over the tick in that cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime <= 64'd0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= bus_wdata;
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= bus_wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp: software rewrites it to clear the timer source
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            if (wr_mtimecmp_lo) begin
                mtimecmp[31:0] <= bus_wdata;
            end
            if (wr_mtimecmp_hi) begin
                mtimecmp[63:32] <= bus_wdata;
            end
        end
    end

    // Trap request controller: IDLE -> REQ -> SERVICE -> IDLE, no nesting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            irq_req   <= 1'b0;
            irq_cause <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (irq_en && src_active) begin
                        state     <= ST_REQ;
                        irq_req   <= 1'b1;
                        irq_cause <= ext_s ? CAUSE_EXT : CAUSE_TIMER;
                    end
                end
                ST_REQ: begin
                    // Ack has priority over a simultaneous withdraw; a source
                    // that drops on its own does not withdraw the request.
                    if (irq_ack) begin
                        state   <= ST_SERVICE;
                        irq_req <= 1'b0;
                    end else if (!irq_en_nxt) begin
                        state   <= ST_IDLE;
                        irq_req <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (is_mret) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    irq_req <= 1'b0;
                end
            endcase
        end
    end

    // Read mux: selected register while bus_re is high, else zero
    always_comb begin
        bus_rdata = 32'd0;
        if (bus_re) begin
            case (bus_addr)
                A_MTIME_LO:    bus_rdata = mtime[31:0];
                A_MTIME_HI:    bus_rdata = mtime[63:32];
                A_MTIMECMP_LO: bus_rdata = mtimecmp[31:0];
                A_MTIMECMP_HI: bus_rdata = mtimecmp[63:32];
                A_CTRL: begin
                    bus_rdata[0]             = timer_en;
                    bus_rdata[1]             = irq_en;
                    bus_rdata[8 +: PRESC_W]  = prescale;
                    bus_rdata[17:16]         = state;
                end
                default:       bus_rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Machine-level interrupt source for the core: memory-mapped 64-bit mtime/mtimecmp timer plus one external interrupt line.
- Raises trap requests toward the CSR/trap logic and waits for acknowledge, then for MRET, before the next request.
- Acts as the initiator side of the trap handshake that the CSR unit services.

Parameters:
ADDR_W, 5, width of bus_addr (byte address, word aligned)
PRESC_W, 8, width of the prescaler field and counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
bus_addr  input  ADDR_W  register byte address
bus_wdata  input  32  write data
bus_we  input  1  write strobe, single cycle
bus_re  input  1  read enable
bus_rdata  output  32  read data, combinational
ext_irq  input  1  asynchronous external interrupt level
irq_ack  input  1  trap taken by core, single-cycle pulse
is_mret  input  1  MRET retired, single-cycle pulse
irq_req  output  1  trap request, registered
irq_cause  output  32  mcause value for the request, registered
mtip  output  1  timer pending level (mtime >= mtimecmp), combinational from registers

Behaviour:
- Register map:
  - 0x00 mtime[31:0]
  - 0x04 mtime[63:32]
  - 0x08 mtimecmp[31:0]
  - 0x0C mtimecmp[63:32]
  - 0x10 CTRL: bit0 timer_en, bit1 irq_en, [15:8] prescale; read-only [17:16] FSM state (IDLE=0, REQ=1, SERVICE=2).
  - Unmapped reads return 0. Unmapped writes are ignored.
- Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, prescaler counter=0, sync flops=0, state IDLE, irq_req=0, irq_cause=0, mtip=0.
- bus_rdata: selected register when bus_re=1, else 0.
- Prescaler and mtime increment:
  - Prescaler counter runs only when timer_en=1.
  - A tick occurs when counter==prescale; the counter then clears to 0. prescale=0 gives a tick every cycle; prescale=N gives a tick every N+1 cycles.
  - Each tick increments mtime by 1 as a full 64-bit add with carry into the high word. FFFF_FFFF_FFFF_FFFF wraps to 0.
  - Clearing timer_en freezes mtime and clears the prescaler counter.
- Writes to mtime:
  - A write to either mtime half loads that half from bus_wdata. The other half holds its value and no increment occurs that cycle (write wins over tick).
  - Any CTRL write clears the prescaler counter.
- mtip = (mtime >= mtimecmp), unsigned 64-bit compare.
- ext_irq passes through a 2-flop synchronizer, giving ext_s; latency 2 cycles.
- FSM:
  - IDLE: when irq_en and (ext_s or mtip), go to REQ the next cycle and set irq_req=1. Latch irq_cause = 32'h8000_000B if ext_s (external has priority), else 32'h8000_0007.
  - REQ: irq_req and irq_cause stay stable until irq_ack. On irq_ack, go to SERVICE and drop irq_req the next cycle. If irq_en is cleared while in REQ, go to IDLE and drop irq_req; the request is withdrawn. If the source deasserts, the request is still held.
  - SERVICE: irq_req=0 and sources are ignored (no nesting). On is_mret, go to IDLE. irq_cause holds its last value.
- Ignored pulses: irq_ack in IDLE or SERVICE; is_mret in IDLE or REQ.
- If the source is still active after MRET, a new request is raised: irq_req rises 2 cycles after the is_mret cycle.
- Same-cycle irq_ack and a CTRL write clearing irq_en while in REQ: ack wins, go to SERVICE.
- Software clears the timer source by rewriting mtimecmp. mtip follows in the same cycle the register updates.
- Reset mid-operation returns everything to reset values immediately, including withdrawing irq_req.

Test Plan:
- Reset -> bus reads: mtime=0, mtimecmp=FFFF_FFFF (both halves), CTRL=0; outputs irq_req=0, irq_cause=0, mtip=0.
- Set mtimecmp=5, CTRL=0x3 (prescale 0) -> mtime reaches 5 after 5 ticks; mtip=1; irq_req=1 the next cycle with irq_cause=8000_0007; irq_req holds until an irq_ack pulse, then drops and state reads 2.
- Prescale=3, timer_en=1 for 40 cycles -> mtime=10. Write mtime_lo=FFFF_FFFF, mtime_hi=0 -> after one tick mtime_hi=1, mtime_lo=0.
- Timer pending and ext_irq both asserted -> irq_cause=8000_000B. Ack, then is_mret with ext still high -> irq_req re-rises 2 cycles after MRET.
- In REQ, write CTRL=0x1 (irq_en=0) -> irq_req=0 the next cycle and state IDLE. Then irq_ack/is_mret pulses while IDLE -> no state change.
- Assert rst while in SERVICE -> state IDLE, irq_req=0, mtimecmp=all-ones, mtime=0 immediately.
